dta_buffer_reader: RTL and testbench
====================================

// Module: dta_buffer_reader
// PURPOSE
// Read-side master for the DTA_Buffer pixel line RAM: the write side fills one line, then this block drains it.
// - On LINE_RDY, streams RD_ADDR 0..LINE_LEN-1 into the buffer and collects RD_DTA.
// - Emits pixels in address order on a VLD/RDY stream towards display/processing.
// - Pulses LINE_ACK when the line is fully drained, so the writer may refill.
// PARAMETERS
// LINE_LEN    640  pixels per line; 1..2048
// ADDR_W      11   RD_ADDR width; 2**ADDR_W >= LINE_LEN
// DTA_W       16   pixel width (RGB565)
// FIFO_DEPTH  4    output FIFO entries; >=3 required for 1 pixel/clk
// PORTS
// i_clk      in   1       clock, all logic on rising edge
// i_rst_n    in   1       asynchronous active-low reset
// LINE_RDY   in   1       1-cycle pulse: buffer holds a complete line
// RD_ADDR    out  ADDR_W  read address to DTA_Buffer
// RD_DTA     in   DTA_W   buffer read data; valid one cycle after RD_ADDR
// O_PIXEL    out  DTA_W   output pixel (FIFO head)
// O_VLD      out  1       O_PIXEL valid
// O_RDY      in   1       downstream accepts; transfer = O_VLD & O_RDY
// LINE_ACK   out  1       1-cycle pulse: last pixel of line transferred
// BUSY       out  1       high in any state other than IDLE
// OVR        out  1       sticky: LINE_RDY arrived while BUSY
// BEHAVIOUR
// - Reset (async, any time incl. mid-line): state=IDLE, RD_ADDR=0, O_PIXEL=0, O_VLD=0, LINE_ACK=0, BUSY=0, OVR=0; FIFO, credit and issue pipe cleared; RD_DTA returning for a pre-reset issue is dropped.
// - FSM IDLE -> READ on LINE_RDY; READ -> DRAIN after address LINE_LEN-1 issued; DRAIN -> DONE when credit==0; DONE -> IDLE unconditionally (1 cycle, LINE_ACK=1).
// - Issue: in READ, address counter ctr issued when (credit - pop) < FIFO_DEPTH, pop = O_VLD&O_RDY this cycle.
// - credit = FIFO entries + reads in flight; +1 per issue, -1 per pop, both same cycle => unchanged.
// - RD_ADDR = ctr (combinational from registered ctr); ctr++ per issue; held when stalled; reset to 0 on entry to READ.
// - RAM reads every cycle; a 1-bit issue flag delayed 1 cycle marks which RD_DTA to capture; only flagged data written to FIFO.
// - Latency: LINE_RDY sampled at edge E0 -> RD_ADDR=0 presented cycle after E0 -> data written at E2 -> O_VLD=1 after E2 (2 clocks from first address).
// - O_RDY held 1, FIFO_DEPTH>=3: one pixel per clock, no bubbles; line of N pixels spans N+2 clocks from first address to last transfer.
// - O_RDY low: O_PIXEL/O_VLD held stable; issue stops once credit hits FIFO_DEPTH; no data lost or reordered.
// - FIFO never overflows (guaranteed by credit); O_VLD = FIFO non-empty.
// - LINE_ACK asserted only in DONE, exactly once per line, never while O_VLD=1.
// - LINE_RDY while BUSY (incl. DONE): ignored, OVR set; OVR cleared only by reset.
// - LINE_LEN=1: single issue, READ->DRAIN after one cycle.
// - RD_ADDR never exceeds LINE_LEN-1; after line, holds LINE_LEN-1 until next READ entry.
// TESTING
// 1 Reset: i_rst_n=0 mid-READ -> all outputs 0 asynchronously; after release, LINE_RDY restarts at RD_ADDR=0.
// 2 LINE_LEN=5, RAM preloaded FFFE,6768,0019,0079,0706, O_RDY=1 -> O_PIXEL same order on 5 consecutive clocks, first 2 clocks after RD_ADDR=0; LINE_ACK once, cycle after 0706.
// 3 Same line, O_RDY toggling 1010... and low for 6 clocks mid-line -> all 5 pixels in order, none duplicated; credit peaks at 4; RD_ADDR stalls.
// 4 LINE_RDY pulsed again during READ -> ignored, OVR=1 sticky, line output unchanged; LINE_RDY after LINE_ACK starts new line from addr 0.
// 5 LINE_LEN=1, RAM[0]=0706 -> one transfer 0706, LINE_ACK one cycle later, BUSY low next.
// 6 LINE_LEN=2048, random O_RDY -> 2048 pixels match RAM, RD_ADDR max 0x7FF, exactly one LINE_ACK.

Source files
------------

// File: rtl/dta_buffer_reader.sv
// -----------------------------------------------------------------------------
// dta_buffer_reader
//
// Read-side master for the DTA_Buffer pixel line RAM. When the writer signals
// a full line (LINE_RDY) this block walks RD_ADDR from 0 to LINE_LEN-1 and
// captures RD_DTA, which arrives one cycle after its address. The captured
// pixels go into a small output FIFO and are presented in address order on a
// VLD/RDY stream. When the line has been fully transferred, LINE_ACK pulses
// for one cycle so that the writer may refill the buffer.
//
// Ports
//   i_clk      in   1        clock, rising edge
//   i_rst_n    in   1        asynchronous active-low reset
//   LINE_RDY   in   1        1-cycle pulse: buffer holds a complete line
//   RD_ADDR    out  ADDR_W   read address to DTA_Buffer
//   RD_DTA     in   DTA_W    buffer read data, valid one cycle after RD_ADDR
//   O_PIXEL    out  DTA_W    output pixel (FIFO head), 0 when O_VLD is low
//   O_VLD      out  1        O_PIXEL valid (FIFO non-empty)
//   O_RDY      in   1        downstream accepts
//   LINE_ACK   out  1        1-cycle pulse: line fully drained
//   BUSY       out  1        high whenever the FSM is not idle
//   OVR        out  1        sticky: LINE_RDY arrived while busy
//   dbg_state  out  2        current FSM state (0 idle, 1 read, 2 drain, 3 done)
//
// Output handshake: a pixel moves exactly on a rising edge where O_VLD and
// O_RDY are both high. Once O_VLD is raised, O_VLD and O_PIXEL stay stable
// until that transfer happens; O_RDY may change freely and has no
// combinational path to O_VLD.
// -----------------------------------------------------------------------------
module dta_buffer_reader #(
    parameter int LINE_LEN   = 640,
    parameter int ADDR_W     = 11,
    parameter int DTA_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              LINE_RDY,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [DTA_W-1:0]  RD_DTA,
    output logic [DTA_W-1:0]  O_PIXEL,
    output logic              O_VLD,
    input  logic              O_RDY,
    output logic              LINE_ACK,
    output logic              BUSY,
    output logic              OVR,
    output logic [1:0]        dbg_state
);

    // Credit counts up to FIFO_DEPTH, FIFO pointers index FIFO_DEPTH slots.
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);
    localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0]     LAST_SLOT = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ctr;
    logic [ADDR_W-1:0] ctr_nxt;
    logic [CW-1:0]     credit;
    logic [CW-1:0]     credit_nxt;
    logic [CW-1:0]     credit_after_pop;
    logic              issue;
    logic              issue_d;
    logic              pop;
    logic              ovr_q;

    logic [DTA_W-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Issue control
    // -------------------------------------------------------------------------
    assign pop = O_VLD & O_RDY;

    // A pop always has a FIFO entry behind it, so credit >= 1 whenever pop is
    // high and this subtraction cannot wrap.
    assign credit_after_pop = credit - CW'(pop);

    // Credit covers FIFO entries plus reads still in the RAM pipe, so issuing
    // only while it is below FIFO_DEPTH guarantees every returning word has a
    // free slot. Counting this cycle's pop lets issue continue back-to-back
    // at full rate.
    assign issue = (state == S_READ) && (credit_after_pop < DEPTH_C);

    assign credit_nxt = credit_after_pop + CW'(issue);
    assign count_nxt  = count + CW'(issue_d) - CW'(pop);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            ctr    <= '0;
            credit <= '0;
            ovr_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            ctr    <= ctr_nxt;
            credit <= credit_nxt;
            if (LINE_RDY && (state != S_IDLE)) begin
                ovr_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ctr_nxt   = ctr;
        case (state)
            S_IDLE: begin
                if (LINE_RDY) begin
                    state_nxt = S_READ;
                    ctr_nxt   = '0;
                end
            end
            S_READ: begin
                if (issue) begin
                    // The counter stops on the last address so RD_ADDR never
                    // leaves the line and holds there until the next line.
                    if (ctr == LAST_ADDR) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        ctr_nxt = ctr + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as soon as the last pop empties the credit, so the
                // acknowledge lands on the cycle right after the last pixel.
                if (credit_after_pop == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // RAM return pipe and output FIFO
    // -------------------------------------------------------------------------
    // The RAM is read every cycle; issue_d marks the single cycle in which
    // RD_DTA belongs to an address this block actually issued. Clearing it on
    // reset drops any word returning for a pre-reset issue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            issue_d <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            issue_d <= issue;
            count   <= count_nxt;
            if (issue_d) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
        end
    end

    // Storage needs no reset: O_PIXEL is masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (issue_d) begin
            mem[wr_ptr] <= RD_DTA;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign RD_ADDR   = ctr;
    assign O_VLD     = (count != '0);
    assign O_PIXEL   = O_VLD ? mem[rd_ptr] : '0;
    assign LINE_ACK  = (state == S_DONE);
    assign BUSY      = (state != S_IDLE);
    assign OVR       = ovr_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_dta_buffer_reader.sv
// -----------------------------------------------------------------------------
// tb_dta_buffer_reader
//
// Three reader instances with line lengths 5, 1 and 2048, each attached to its
// own line RAM model. The reference model treats a line as a list of RAM words:
// accepting LINE_RDY loads the expected queue with ram[0..LEN-1], every
// transfer must pop the queue head, and LINE_ACK must follow the last transfer
// by one cycle with nothing left. Directed tests add hand-computed latencies
// and values.
// -----------------------------------------------------------------------------
module tb_dta_buffer_reader;

  localparam int NI     = 3;
  localparam int ADDR_W = 11;
  localparam int DTA_W  = 16;
  localparam int LENS [NI] = '{5, 1, 2048};

  // ---------------------------------------------------------------------------
  // Clock / reset / DUTs
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  logic              line_rdy  [NI];
  logic              o_rdy     [NI];
  logic [ADDR_W-1:0] rd_addr   [NI];
  logic [DTA_W-1:0]  rd_dta    [NI];
  logic [DTA_W-1:0]  o_pixel   [NI];
  logic              o_vld     [NI];
  logic              line_ack  [NI];
  logic              busy      [NI];
  logic              ovr       [NI];
  logic [1:0]        dbg_state [NI];

  logic [DTA_W-1:0]  ram [NI][2048];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read line RAM: data one cycle after the address.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) rd_dta[g] <= ram[g][rd_addr[g]];
  end

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    dta_buffer_reader #(
      .LINE_LEN  (LENS[gi]),
      .ADDR_W    (ADDR_W),
      .DTA_W     (DTA_W),
      .FIFO_DEPTH(4)
    ) u_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .LINE_RDY (line_rdy[gi]),
      .RD_ADDR  (rd_addr[gi]),
      .RD_DTA   (rd_dta[gi]),
      .O_PIXEL  (o_pixel[gi]),
      .O_VLD    (o_vld[gi]),
      .O_RDY    (o_rdy[gi]),
      .LINE_ACK (line_ack[gi]),
      .BUSY     (busy[gi]),
      .OVR      (ovr[gi]),
      .dbg_state(dbg_state[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Scoreboard / model state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic [DTA_W-1:0] exp_q [NI][$];
  bit               m_busy [NI];
  bit               m_ovr  [NI];
  bit               hold_v [NI];
  logic [DTA_W-1:0] hold_p [NI];
  int               acks [NI];
  int               npix [NI];
  int               start_cyc [NI];
  int               first_cyc [NI];
  int               last_cyc [NI];
  int               ack_cyc [NI];
  int               max_addr [NI];
  logic [DTA_W-1:0] first_pix [NI];
  logic [DTA_W-1:0] last_pix [NI];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called once per cycle at the falling edge for every instance.
  task automatic model_check();
    logic [DTA_W-1:0] e;
    for (int g = 0; g < NI; g++) begin
      if (!rst_n) begin
        chk($sformatf("rst_flags[%0d]", g),
            32'({o_vld[g], busy[g], ovr[g], line_ack[g]}), 32'd0);
        chk($sformatf("rst_addr[%0d]", g), 32'(rd_addr[g]), 32'd0);
        chk($sformatf("rst_pixel[%0d]", g), 32'(o_pixel[g]), 32'd0);
        chk($sformatf("rst_state[%0d]", g), 32'(dbg_state[g]), 32'd0);
        exp_q[g].delete();
        m_busy[g] = 1'b0;
        m_ovr[g]  = 1'b0;
        hold_v[g] = 1'b0;
        continue;
      end
      chk($sformatf("busy[%0d]", g), 32'(busy[g]), 32'(m_busy[g]));
      chk($sformatf("ovr[%0d]", g), 32'(ovr[g]), 32'(m_ovr[g]));
      chk($sformatf("addr_range[%0d]", g),
          32'(32'(rd_addr[g]) <= 32'(LENS[g] - 1)), 32'd1);
      if (m_busy[g] && (32'(rd_addr[g]) > 32'(max_addr[g]))) max_addr[g] = int'(rd_addr[g]);
      chk($sformatf("vld_without_data[%0d]", g),
          32'(o_vld[g] && (exp_q[g].size() == 0)), 32'd0);
      if (hold_v[g]) begin
        chk($sformatf("hold_vld[%0d]", g), 32'(o_vld[g]), 32'd1);
        chk($sformatf("hold_pixel[%0d]", g), 32'(o_pixel[g]), 32'(hold_p[g]));
      end
      if (o_vld[g] && o_rdy[g] && (exp_q[g].size() != 0)) begin
        e = exp_q[g].pop_front();
        chk($sformatf("pixel[%0d]#%0d", g, npix[g]), 32'(o_pixel[g]), 32'(e));
        if (npix[g] == 0) begin
          first_cyc[g] = cyc;
          first_pix[g] = o_pixel[g];
        end
        npix[g]++;
        last_cyc[g] = cyc;
        last_pix[g] = o_pixel[g];
      end
      hold_v[g] = o_vld[g] && !o_rdy[g];
      hold_p[g] = o_pixel[g];
      if (line_ack[g]) begin
        chk($sformatf("ack_in_line[%0d]", g), 32'(m_busy[g]), 32'd1);
        chk($sformatf("ack_left[%0d]", g), 32'(exp_q[g].size()), 32'd0);
        chk($sformatf("ack_vld[%0d]", g), 32'(o_vld[g]), 32'd0);
        chk($sformatf("ack_after_last[%0d]", g), 32'(cyc - last_cyc[g]), 32'd1);
        acks[g]++;
        ack_cyc[g] = cyc;
      end
      if (line_rdy[g]) begin
        if (m_busy[g]) begin
          m_ovr[g] = 1'b1;
        end else begin
          for (int i = 0; i < LENS[g]; i++) exp_q[g].push_back(ram[g][i]);
          m_busy[g]    = 1'b1;
          start_cyc[g] = cyc + 1;
          npix[g]      = 0;
          max_addr[g]  = 0;
        end
      end
      if (line_ack[g]) m_busy[g] = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  // mode 0: O_RDY=1; 1: O_RDY low 6 cycles after start then toggling;
  // 2: random O_RDY; 3: O_RDY=1 with a second LINE_RDY during the read.
  task automatic run_line(input int g, input int mode, input int budget);
    int a0;
    int k;
    a0 = acks[g];
    k  = 0;
    line_rdy[g] = 1'b1;
    while ((acks[g] == a0) && (k < budget)) begin
      case (mode)
        1:       o_rdy[g] = (k < 7) ? 1'b0 : k[0];
        2:       o_rdy[g] = 1'($urandom_range(0, 1));
        default: o_rdy[g] = 1'b1;
      endcase
      if ((mode == 3) && (k == 3)) line_rdy[g] = 1'b1;
      if (k == 1) begin
        chk($sformatf("start_addr[%0d]", g), 32'(rd_addr[g]), 32'd0);
        chk($sformatf("start_busy[%0d]", g), 32'(busy[g]), 32'd1);
      end
      if ((mode == 1) && (k == 6)) begin
        // Four reads outstanding, fifth address stalled.
        chk("stall_addr", 32'(rd_addr[g]), 32'd4);
        chk("stall_vld", 32'(o_vld[g]), 32'd1);
        chk("stall_pixel", 32'(o_pixel[g]), 32'(ram[g][0]));
      end
      step();
      line_rdy[g] = 1'b0;
      k++;
    end
    o_rdy[g] = 1'b1;
    chk($sformatf("line_done[%0d]", g), 32'(acks[g] - a0), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [DTA_W-1:0] pat [5];
    pat = '{16'hFFFE, 16'h6768, 16'h0019, 16'h0079, 16'h0706};
    for (int g = 0; g < NI; g++) begin
      line_rdy[g] = 1'b0;
      o_rdy[g]    = 1'b0;
      acks[g]     = 0;
      npix[g]     = 0;
      last_cyc[g] = 0;
      for (int i = 0; i < 2048; i++) ram[g][i] = '0;
    end
    for (int i = 0; i < 5; i++) ram[0][i] = pat[i];
    ram[1][0] = 16'h0706;
    for (int i = 0; i < 2048; i++) ram[2][i] = 16'($urandom);

    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset in the middle of a line: outputs clear without a clock edge.
    o_rdy[0] = 1'b1;
    line_rdy[0] = 1'b1;
    step();
    line_rdy[0] = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy[0]), 32'd0);
    chk("async_addr", 32'(rd_addr[0]), 32'd0);
    chk("async_vld", 32'(o_vld[0]), 32'd0);
    chk("async_pixel", 32'(o_pixel[0]), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Five-pixel line at full rate.
    run_line(0, 0, 50);
    chk("t2_npix", 32'(npix[0]), 32'd5);
    chk("t2_first_pix", 32'(first_pix[0]), 32'hFFFE);
    chk("t2_last_pix", 32'(last_pix[0]), 32'h0706);
    chk("t2_first_latency", 32'(first_cyc[0] - start_cyc[0]), 32'd2);
    chk("t2_span", 32'(last_cyc[0] - first_cyc[0]), 32'd4);
    chk("t2_ack", 32'(ack_cyc[0] - last_cyc[0]), 32'd1);
    step();

    // Same line with back-pressure.
    run_line(0, 1, 80);
    chk("t3_npix", 32'(npix[0]), 32'd5);
    chk("t3_first_pix", 32'(first_pix[0]), 32'hFFFE);
    chk("t3_last_pix", 32'(last_pix[0]), 32'h0706);
    step();

    // Overrun during read, then a clean new line.
    chk("t4_ovr_before", 32'(ovr[0]), 32'd0);
    run_line(0, 3, 50);
    chk("t4_npix", 32'(npix[0]), 32'd5);
    chk("t4_ovr", 32'(ovr[0]), 32'd1);
    step();
    run_line(0, 0, 50);
    chk("t4_npix_next", 32'(npix[0]), 32'd5);
    chk("t4_ovr_sticky", 32'(ovr[0]), 32'd1);
    chk("t4_first_latency", 32'(first_cyc[0] - start_cyc[0]), 32'd2);

    // Single-pixel line.
    run_line(1, 0, 20);
    chk("t5_npix", 32'(npix[1]), 32'd1);
    chk("t5_pix", 32'(first_pix[1]), 32'h0706);
    chk("t5_first_latency", 32'(first_cyc[1] - start_cyc[1]), 32'd2);
    chk("t5_ack", 32'(ack_cyc[1] - last_cyc[1]), 32'd1);
    chk("t5_busy_after", 32'(busy[1]), 32'd0);
    step();

    // Full 2048-pixel line with random back-pressure.
    run_line(2, 2, 20000);
    chk("t6_npix", 32'(npix[2]), 32'd2048);
    chk("t6_max_addr", 32'(max_addr[2]), 32'h7FF);
    chk("t6_last_pix", 32'(last_pix[2]), 32'(ram[2][2047]));

    repeat (5) step();
    chk("acks_inst0", 32'(acks[0]), 32'd4);
    chk("acks_inst1", 32'(acks[1]), 32'd1);
    chk("acks_inst2", 32'(acks[2]), 32'd1);
    chk("hold_last_addr", 32'(rd_addr[2]), 32'h7FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
